addsub_iter: RTL and testbench
==============================

# addsub_iter

Parametrised, multi-cycle two's-complement add/subtract unit for the ALU datapath. It processes operands CHUNK bits per cycle, rippling the carry through a registered chunk adder, which keeps the carry chain short for wide datapaths. It uses a valid/ready handshake on both sides and reports signed overflow and unsigned carry/borrow. It is the sequential, width-generic successor to the fixed 32-bit combinational subtractor in the ALU operations set.

## Interface
- WIDTH, 32: operand/result width in bits.
- CHUNK, 8: bits processed per cycle.
  - WIDTH % CHUNK must be 0 and CHUNK ≥ 1; any other value is an elaboration error.
  - N = WIDTH/CHUNK.
- clock  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op presented.
- in_ready  out  1  unit can accept; high only in IDLE.
- op_sub  in  1  0 = A+B, 1 = A−B.
- data_operandA  in  WIDTH  operand A.
- data_operandB  in  WIDTH  operand B.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer takes result.
- data_result  out  WIDTH  sum or difference.
- overflow  out  1  signed overflow.
- carry  out  1  final carry out of bit WIDTH−1; for a subtract, 1 means no borrow.

## Operation
- States and transitions:
  - IDLE → RUN on in_valid && in_ready.
  - RUN → DONE after the last chunk.
  - DONE → IDLE on out_valid && out_ready.
- Accept: latch A, effective B (B, or ~B when op_sub = 1), op_sub, and carry-in. Carry-in is 1 for a subtract, 0 for an add. Inputs are ignored after acceptance.
- RUN: chunk index k counts 0..N−1.
  - Each cycle adds A[k], Beff[k] and the registered carry.
  - The sum is written to result[k] and the chunk carry-out is registered.
- Overflow: (A[msb] == Beff[msb]) && (result[msb] != A[msb]), computed after the last chunk.
- Carry: the carry out of chunk N−1.
- DONE: data_result, overflow and carry are held stable until the handshake completes. No new operand is accepted in DONE.
- Reset (any state, including mid-RUN):
  - State returns to IDLE; the in-flight operation is discarded.
  - Output reset values: data_result = 0, overflow = 0, carry = 0, out_valid = 0.
  - in_ready is 1 once reset_n is released.
- Edge cases:
  - N = 1 (CHUNK = WIDTH) is legal and gives a single RUN cycle.
  - A − 0 yields carry = 1.
  - 0 − 0 yields result 0, carry 1, overflow 0.

## Timing
- Acceptance at edge T: out_valid rises after edge T+N (N RUN cycles).
- Minimum issue interval: N+2 cycles, made up of:
  - the accept cycle,
  - N RUN cycles,
  - the DONE cycle, when out_ready is already high.
- out_ready low stalls in DONE indefinitely; all outputs stay constant.
- in_ready is combinational from state only, with no path from in_valid. out_valid is registered.

## Configuration
- ADDSUB_SAT_EN defined: on overflow, data_result is clamped instead of wrapped.
  - If A[msb] = 0, the result is 0 followed by all 1s (max positive).
  - If A[msb] = 1, the result is 1 followed by all 0s (min negative).
  - overflow is still asserted. carry is unaffected.
- ADDSUB_SAT_EN undefined: data_result is the wrapped two's-complement result.

## Structure
- Shared package alu_pkg:
  - ALU opcode constants (ADD, SUB).
  - The state enum typedef (IDLE, RUN, DONE).
- Sub-module addsub_slice: a combinational CHUNK-bit adder with carry-in and carry-out, instantiated once. The top level holds the state machine, chunk counter, operand/result registers and carry register.

## Test plan
All scenarios use WIDTH = 32, CHUNK = 8.
- 0x000000FF + 0x00000001, op_sub = 0 → result 0x00000100, overflow 0, carry 0; out_valid exactly 4 cycles after accept.
- 5 − 7 → 0xFFFFFFFE, overflow 0, carry 0 (borrow).
- 0x7FFFFFFF + 1 → overflow 1.
  - Without ADDSUB_SAT_EN: 0x80000000.
  - With ADDSUB_SAT_EN: 0x7FFFFFFF.
- 0x80000000 − 1 → overflow 1, carry 1.
  - Without ADDSUB_SAT_EN: 0x7FFFFFFF.
  - With ADDSUB_SAT_EN: 0x80000000.
- Backpressure: hold out_ready low for 5 cycles in DONE while driving in_valid with new operands.
  - Outputs stay constant and in_ready stays 0.
  - After the handshake, the next op is accepted and its result is correct.
- reset_n pulsed low during the second RUN cycle.
  - Outputs go to 0 immediately and in_ready is 1 after release.
  - A following 0x12345678 − 0x12345678 → 0, carry 1, overflow 0.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU datapath blocks.
//   - ALU opcode constants (OP_ADD / OP_SUB) as driven on op_sub
//   - state_e : control state of the iterative add/subtract unit
// -----------------------------------------------------------------------------
package alu_pkg;

    // Opcode encoding on the op_sub pin
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Control states of addsub_iter
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/addsub_slice.sv
// -----------------------------------------------------------------------------
// addsub_slice
// Combinational CHUNK-bit adder with carry in and carry out. Subtraction is
// handled by the caller (inverted B plus carry-in of 1).
// Ports:
//   a, b  : CHUNK-bit addends
//   cin   : carry in
//   sum   : CHUNK-bit sum
//   cout  : carry out of the top bit
// -----------------------------------------------------------------------------
module addsub_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] total_s;

    // Widen by one bit so the carry out falls out of the addition
    always_comb begin
        total_s = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        sum     = total_s[CHUNK-1:0];
        cout    = total_s[CHUNK];
    end

endmodule

// File: rtl/addsub_iter.sv
// -----------------------------------------------------------------------------
// addsub_iter
// Multi-cycle two's-complement add/subtract. Operands are processed CHUNK bits
// per cycle through one addsub_slice, with the inter-chunk carry registered.
// Optional build macro: ADDSUB_SAT_EN -- clamp data_result on signed overflow
// (max positive / min negative) instead of wrapping.
// Ports:
//   clock, reset_n           : clock, asynchronous active-low reset
//   in_valid / in_ready      : operand handshake (in_ready high only in IDLE)
//   op_sub                   : 0 = A+B, 1 = A-B
//   data_operandA/B          : WIDTH-bit operands
//   out_valid / out_ready    : result handshake (out_valid registered)
//   data_result              : sum or difference
//   overflow                 : signed overflow
//   carry                    : carry out of msb (subtract: 1 = no borrow)
// -----------------------------------------------------------------------------
module addsub_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             overflow,
    output logic             carry
);

    localparam int N     = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $error("addsub_iter: CHUNK must be at least 1");
        end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $error("addsub_iter: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_e             state_r;
    logic [CNT_W-1:0]   idx_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;        // effective B (already inverted for subtract)
    logic [WIDTH-1:0]   res_r;      // partial result being assembled
    logic               carry_r;    // carry between chunks
    logic [WIDTH-1:0]   data_result_r;
    logic               overflow_r;
    logic               carry_out_r;
    logic               out_valid_r;

    int                 base_s;
    logic [CHUNK-1:0]   sum_s;
    logic               cout_s;
    logic [WIDTH-1:0]   full_s;
    logic [WIDTH-1:0]   final_s;
    logic               ovf_s;
    logic               last_s;

    // Clamp value for a saturating overflow, chosen by the sign of A
    function automatic logic [WIDTH-1:0] sat_value(input logic a_msb);
        logic [WIDTH-1:0] v;
        if (a_msb) begin
            v = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            v = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return v;
    endfunction

    assign in_ready    = (state_r == ST_IDLE);
    assign out_valid   = out_valid_r;
    assign data_result = data_result_r;
    assign overflow    = overflow_r;
    assign carry       = carry_out_r;

    // Chunk currently selected by the counter
    always_comb begin
        base_s = int'(idx_r) * CHUNK;
        last_s = (idx_r == CNT_W'(N - 1));
    end

    addsub_slice #(.CHUNK(CHUNK)) u_slice (
        .a    (a_r[base_s +: CHUNK]),
        .b    (b_r[base_s +: CHUNK]),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // Merge this cycle's chunk into the result; overflow is only meaningful
    // on the last chunk, where sum_s holds the result msb.
    always_comb begin
        full_s               = res_r;
        full_s[base_s +: CHUNK] = sum_s;
        ovf_s                = (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                               (sum_s[CHUNK-1] != a_r[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
        if (ovf_s) begin
            final_s = sat_value(a_r[WIDTH-1]);
        end else begin
            final_s = full_s;
        end
`else
        final_s = full_s;
`endif
    end

    // Control FSM, operand capture, chunk iteration and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            idx_r         <= {CNT_W{1'b0}};
            a_r           <= {WIDTH{1'b0}};
            b_r           <= {WIDTH{1'b0}};
            res_r         <= {WIDTH{1'b0}};
            carry_r       <= 1'b0;
            data_result_r <= {WIDTH{1'b0}};
            overflow_r    <= 1'b0;
            carry_out_r   <= 1'b0;
            out_valid_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r     <= data_operandA;
                        b_r     <= (op_sub == OP_SUB) ? ~data_operandB : data_operandB;
                        carry_r <= (op_sub == OP_SUB);
                        idx_r   <= {CNT_W{1'b0}};
                        res_r   <= {WIDTH{1'b0}};
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    res_r   <= full_s;
                    carry_r <= cout_s;
                    if (last_s) begin
                        data_result_r <= final_s;
                        overflow_r    <= ovf_s;
                        carry_out_r   <= cout_s;
                        out_valid_r   <= 1'b1;
                        state_r       <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r + CNT_W'(1);
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r     <= ST_DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_iter.sv
// -----------------------------------------------------------------------------
// tb_addsub_iter
// Directed bench for addsub_iter (WIDTH=32, CHUNK=8) with hand-computed
// expectations. Honours ADDSUB_SAT_EN for the overflow cases.
// -----------------------------------------------------------------------------
module tb_addsub_iter;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        op_sub;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_result;
    logic        overflow;
    logic        carry;

    int n_checks = 0;
    int n_errors = 0;

    addsub_iter #(.WIDTH(32), .CHUNK(8)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .op_sub        (op_sub),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .data_result   (data_result),
        .overflow      (overflow),
        .carry         (carry)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one operation and let it be accepted on the next rising edge
    task automatic start_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic sub);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        op_sub        = sub;
        in_valid      = 1'b1;
        check_eq({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        in_valid      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'hCAFE_F00D;
        op_sub        = ~sub;
    endtask

    // Bounded wait for out_valid; latency counted in edges after the accept
    task automatic wait_done(input string tag);
        int cyc = 0;
        do begin
            @(posedge clock);
            #1;
            cyc++;
        end while (!out_valid && cyc < 20);
        check_eq({tag, "_latency"}, 32'(cyc), 32'd4);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp_res,
                          input logic exp_ovf, input logic exp_carry);
        start_op(tag, a, b, sub);
        wait_done(tag);
        check_eq({tag, "_result"},   data_result,          exp_res);
        check_eq({tag, "_overflow"}, {31'd0, overflow},    {31'd0, exp_ovf});
        check_eq({tag, "_carry"},    {31'd0, carry},       {31'd0, exp_carry});
        @(posedge clock);
        #1;
        check_eq({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    logic [31:0] held_res;
    logic [31:0] exp_ovf_add;
    logic [31:0] exp_ovf_sub;

    initial begin
`ifdef ADDSUB_SAT_EN
        exp_ovf_add = 32'h7FFF_FFFF;
        exp_ovf_sub = 32'h8000_0000;
`else
        exp_ovf_add = 32'h8000_0000;
        exp_ovf_sub = 32'h7FFF_FFFF;
`endif
        reset_n       = 1'b0;
        in_valid      = 1'b0;
        op_sub        = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        out_ready     = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_result",    data_result,          32'd0);
        check_eq("rst_out_valid", {31'd0, out_valid},   32'd0);
        check_eq("rst_overflow",  {31'd0, overflow},    32'd0);
        check_eq("rst_carry",     {31'd0, carry},       32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Functional vectors
        run_op("add_ff_1",  32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        run_op("sub_5_7",   32'd5,         32'd7,         1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, exp_ovf_add,   1'b1, 1'b0);
        run_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, exp_ovf_sub,   1'b1, 1'b1);
        run_op("sub_a_0",   32'h0000_1234, 32'h0000_0000, 1'b1, 32'h0000_1234, 1'b0, 1'b1);
        run_op("sub_0_0",   32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1);

        // Backpressure in DONE while new operands are offered
        out_ready = 1'b0;
        start_op("bp", 32'h0000_0010, 32'h0000_0020, 1'b1);
        wait_done("bp");
        check_eq("bp_result", data_result, 32'hFFFF_FFF0);
        held_res = data_result;
        @(negedge clock);
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        op_sub        = 1'b0;
        in_valid      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            check_eq("bp_hold_result",  data_result,        held_res);
            check_eq("bp_hold_valid",   {31'd0, out_valid}, 32'd1);
            check_eq("bp_hold_inready", {31'd0, in_ready},  32'd0);
            check_eq("bp_hold_carry",   {31'd0, carry},     32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        check_eq("bp_release_valid", {31'd0, out_valid}, 32'd0);
        run_op("after_bp", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);

        // Reset during the second RUN cycle
        start_op("mid_rst", 32'h1111_1111, 32'h2222_2222, 1'b0);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_result",    data_result,        32'd0);
        check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_eq("mid_rst_overflow",  {31'd0, overflow},  32'd0);
        check_eq("mid_rst_carry",     {31'd0, carry},     32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        run_op("post_rst", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'd0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
